// File: rtl/ad_timebase_ctrl.sv
// ad_timebase_ctrl
// Timebase source for the AD sample-clock selector. It does three things:
//   - divides sys_clk into five 50%-duty sample clocks,
//   - debounces the front-panel up/down keys and converts each press into a
//     one-hot EN select code,
//   - pulses switch_pulse for one cycle whenever the timebase changes.
//
// Ports:
//   sys_clk      in   1  system clock, rising edge
//   rst          in   1  synchronous reset, active-high
//   key_up       in   1  raw asynchronous key; selects a faster timebase
//   key_down     in   1  raw asynchronous key; selects a slower timebase
//   AD_clk       out  5  divided clocks; bit k toggles every DIVk cycles
//   EN           out  8  one-hot select, 8'b1 << (sel_idx+1)
//   sel_idx      out  3  current timebase index, 0..4
//   switch_pulse out  1  one-cycle pulse in the cycle EN changes
//
// Optional feature: define AD_TB_AUTOREPEAT_EN to get key auto-repeat. While a
// debounced key stays high, a further step is issued every REPEAT_CYCLES cycles.
module ad_timebase_ctrl #(
    parameter int DEB_CNT       = 1_000_000,
    parameter int DIV0          = 1,
    parameter int DIV1          = 5,
    parameter int DIV2          = 50,
    parameter int DIV3          = 500,
    parameter int DIV4          = 5000,
    parameter int DEFAULT_SEL   = 4,
    parameter int REPEAT_CYCLES = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_down,
    output logic [4:0] AD_clk,
    output logic [7:0] EN,
    output logic [2:0] sel_idx,
    output logic       switch_pulse
);

    localparam int DW = $clog2(DEB_CNT + 1);
    localparam int DIVS [5] = '{DIV0, DIV1, DIV2, DIV3, DIV4};

    // Index 0 = up, index 1 = down.
    logic [1:0] keys;
    assign keys = {key_down, key_up};

    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]         deb_q, deb_d, deb_dly_q, deb_dly_d;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]         req;

    logic [2:0] sel_q, sel_d;
    logic [7:0] en_q, en_d;
    logic       switch_q, switch_d;
    logic       change;

`ifdef AD_TB_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    // Key path: synchronizer, debounce, edge detect. The debounce counter
    // only runs while the synced level disagrees with the accepted state, so
    // any bounce back to the accepted level restarts the qualification window.
    always_comb begin
        sync1_d   = keys;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_dly_d = deb_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CNT - 1))
                    deb_d[i] = sync2_q[i];
                else
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
        req = deb_q & ~deb_dly_q;
`ifdef AD_TB_AUTOREPEAT_EN
        // Counting starts the cycle after the press request, so repeats land
        // exactly REPEAT_CYCLES, 2*REPEAT_CYCLES, ... after the first step.
        rpt_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (deb_q[i] && deb_dly_q[i]) begin
                if (rpt_cnt_q[i] == RW'(REPEAT_CYCLES - 1))
                    req[i] = 1'b1;
                else
                    rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
            end
        end
`endif
    end

    // Step resolution: simultaneous up/down cancel; saturated steps do nothing.
    always_comb begin
        sel_d  = sel_q;
        change = 1'b0;
        if (req[0] && !req[1] && sel_q != 3'd0) begin
            sel_d  = sel_q - 3'd1;
            change = 1'b1;
        end else if (req[1] && !req[0] && sel_q != 3'd4) begin
            sel_d  = sel_q + 3'd1;
            change = 1'b1;
        end
        en_d     = 8'd1 << (sel_d + 3'd1);
        switch_d = change;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            deb_cnt_q <= '0;
            sel_q     <= 3'(DEFAULT_SEL);
            en_q      <= 8'd1 << (DEFAULT_SEL + 1);
            switch_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            deb_cnt_q <= deb_cnt_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            switch_q  <= switch_d;
        end
    end

`ifdef AD_TB_AUTOREPEAT_EN
    always_ff @(posedge sys_clk) begin
        if (rst) rpt_cnt_q <= '0;
        else     rpt_cnt_q <= rpt_cnt_d;
    end
`endif

    // Dividers. A timebase change restarts every divider so the newly
    // selected clock begins low with a full half-period.
    logic [4:0] ad_clk_q, ad_clk_d;

    for (genvar k = 0; k < 5; k++) begin : g_div
        localparam int DIV = DIVS[k];
        localparam int CW  = $clog2(DIV + 1);

        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d       = cnt_q + 1'b1;
            ad_clk_d[k] = ad_clk_q[k];
            if (cnt_q == CW'(DIV - 1)) begin
                cnt_d       = '0;
                ad_clk_d[k] = ~ad_clk_q[k];
            end
            if (change) begin
                cnt_d       = '0;
                ad_clk_d[k] = 1'b0;
            end
        end

        always_ff @(posedge sys_clk) begin
            if (rst) begin
                cnt_q       <= '0;
                ad_clk_q[k] <= 1'b0;
            end else begin
                cnt_q       <= cnt_d;
                ad_clk_q[k] <= ad_clk_d[k];
            end
        end
    end

    assign AD_clk       = ad_clk_q;
    assign EN           = en_q;
    assign sel_idx      = sel_q;
    assign switch_pulse = switch_q;

endmodule
